// File: rtl/picocode_pkg.sv
// Shared constants and loader state encoding for the picocode RAM slice.
package picocode_pkg;

  localparam int unsigned PICO_ADDR_W = 10;
  localparam int unsigned PICO_DATA_W = 18;
  localparam int unsigned PICO_DEPTH  = 1024;

  typedef enum logic [2:0] {
    RUN  = 3'd0,
    B0   = 3'd1,
    B1   = 3'd2,
    B2   = 3'd3,
    WR   = 3'd4,
    DONE = 3'd5
  } pico_state_e;

endpackage

// File: rtl/picocode_word_asm.sv
// Assembles three host bytes into one 18-bit instruction word, keeps the
// running XOR checksum of every byte taken, and flags a third byte whose
// upper six bits are not zero.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   clr         clear the checksum (new load accepted)
//   byte_en     a host byte transfers this cycle
//   byte_sel    which byte of the word (0: [7:0], 1: [15:8], 2: [17:16])
//   byte_in     host byte
//   word        assembled word
//   csum        XOR of all bytes since the last clr
//   upper_bad   third byte with nonzero [7:2] transferring this cycle
module picocode_word_asm
  import picocode_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   byte_en,
  input  logic [1:0]             byte_sel,
  input  logic [7:0]             byte_in,
  output logic [PICO_DATA_W-1:0] word,
  output logic [7:0]             csum,
  output logic                   upper_bad
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word <= '0;
      csum <= '0;
    end else begin
      if (clr) begin
        csum <= '0;
      end else if (byte_en) begin
        csum <= csum ^ byte_in;
      end
      if (byte_en) begin
        unique case (byte_sel)
          2'd0:    word[7:0]   <= byte_in;
          2'd1:    word[15:8]  <= byte_in;
          default: word[17:16] <= byte_in[1:0];
        endcase
      end
    end
  end

  assign upper_bad = byte_en && (byte_sel == 2'd2) && (|byte_in[7:2]);

endmodule

// File: rtl/picocode_loader.sv
// Owns the single picocode RAM port. In RUN the CPU fetch path is muxed
// straight through; in LOAD the CPU is halted and host bytes are assembled
// into words written sequentially from address 0.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   load_start, load_len       load request and word count (1..1024)
//   host_data/valid/ready      host byte stream handshake
//   cpu_addr, cpu_en           CPU fetch request
//   cpu_halt                   CPU must freeze its PC
//   ram_addr/data_in/en/we     picocode_ram port
//   load_busy, load_done       load in progress / final word written pulse
//   load_err, load_csum        sticky error, XOR of load bytes
module picocode_loader
  import picocode_pkg::*;
#(
  parameter int unsigned ADDR_W = PICO_ADDR_W,
  parameter int unsigned DATA_W = PICO_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic [ADDR_W:0]   load_len,
  input  logic [7:0]        host_data,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_en,
  output logic              cpu_halt,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_en,
  output logic              ram_we,
  output logic              load_busy,
  output logic              load_done,
  output logic              load_err,
  output logic [7:0]        load_csum
);

  pico_state_e       state, state_nxt;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   wcnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic              len_ok;
  logic              start_ok;
  logic              xfer;
  logic [1:0]        byte_sel;
  logic              upper_bad;
  logic [DATA_W-1:0] word;

  assign len_ok   = (load_len != '0) && (32'(load_len) <= PICO_DEPTH);
  assign start_ok = (state == RUN) && load_start && len_ok;
  assign xfer     = host_valid && host_ready;

  picocode_word_asm u_word_asm (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (start_ok),
    .byte_en   (xfer),
    .byte_sel  (byte_sel),
    .byte_in   (host_data),
    .word      (word),
    .csum      (load_csum),
    .upper_bad (upper_bad)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      len_q    <= '0;
      wcnt_q   <= '0;
      addr_q   <= '0;
      load_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == RUN && load_start) begin
        if (len_ok) begin
          len_q    <= load_len;
          wcnt_q   <= '0;
          addr_q   <= '0;
          load_err <= 1'b0;
        end else begin
          load_err <= 1'b1;
        end
      end
      if (upper_bad) begin
        load_err <= 1'b1;
      end
      if (state == WR) begin
        wcnt_q <= wcnt_q + 1'b1;
        addr_q <= addr_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    host_ready  = 1'b0;
    byte_sel    = 2'd0;
    ram_addr    = addr_q;
    ram_data_in = '0;
    ram_en      = 1'b0;
    ram_we      = 1'b0;
    cpu_halt    = (state != RUN);
    load_busy   = (state != RUN);
    load_done   = 1'b0;
    unique case (state)
      RUN: begin
        ram_addr = cpu_addr;
        ram_en   = cpu_en;
        if (start_ok) state_nxt = B0;
      end
      B0: begin
        host_ready = 1'b1;
        byte_sel   = 2'd0;
        if (xfer) state_nxt = B1;
      end
      B1: begin
        host_ready = 1'b1;
        byte_sel   = 2'd1;
        if (xfer) state_nxt = B2;
      end
      B2: begin
        host_ready = 1'b1;
        byte_sel   = 2'd2;
        if (xfer) state_nxt = WR;
      end
      WR: begin
        ram_en      = 1'b1;
        ram_we      = 1'b1;
        ram_data_in = word;
        // Completion is taken from the word count, so the address wrap
        // on a full-depth load never matters.
        state_nxt   = ((wcnt_q + 1'b1) == len_q) ? DONE : B0;
      end
      DONE: begin
        load_done = 1'b1;
        state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

endmodule

// File: tb/tb_picocode_loader.sv
module tb_picocode_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_start;
  logic [10:0] load_len;
  logic [7:0]  host_data;
  logic        host_valid;
  logic        host_ready;
  logic [9:0]  cpu_addr;
  logic        cpu_en;
  logic        cpu_halt;
  logic [9:0]  ram_addr;
  logic [17:0] ram_data_in;
  logic        ram_en;
  logic        ram_we;
  logic        load_busy;
  logic        load_done;
  logic        load_err;
  logic [7:0]  load_csum;

  picocode_loader #(.ADDR_W(10), .DATA_W(18)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_start  (load_start),
    .load_len    (load_len),
    .host_data   (host_data),
    .host_valid  (host_valid),
    .host_ready  (host_ready),
    .cpu_addr    (cpu_addr),
    .cpu_en      (cpu_en),
    .cpu_halt    (cpu_halt),
    .ram_addr    (ram_addr),
    .ram_data_in (ram_data_in),
    .ram_en      (ram_en),
    .ram_we      (ram_we),
    .load_busy   (load_busy),
    .load_done   (load_done),
    .load_err    (load_err),
    .load_csum   (load_csum)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [27:0] wq[$];   // expected writes {addr, data}
  logic [8:0]  dq[$];   // expected done status {err, csum}
  logic [17:0] mem [1024];
  logic        prev_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: RAM model plus scoreboard pops on writes and on load_done.
  initial begin
    logic [27:0] e;
    logic [8:0]  d;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (ram_en && ram_we) begin
          mem[ram_addr] = ram_data_in;
          if (wq.size() == 0) begin
            check("unexpected_write", {12'd0, ram_addr, 10'd0}, 32'hFFFF_FFFF);
          end else begin
            e = wq.pop_front();
            check("write_addr", 32'(ram_addr), 32'(e[27:18]));
            check("write_data", 32'(ram_data_in), 32'(e[17:0]));
          end
        end
        if (load_done) begin
          check("done_pulse_width", 32'(prev_done), 32'd0);
          if (dq.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
          end else begin
            d = dq.pop_front();
            check("done_csum", 32'(load_csum), 32'(d[7:0]));
            check("done_err", 32'(load_err), 32'(d[8]));
            check("done_queue_drained", 32'(wq.size()), 32'd0);
          end
        end
        prev_done = load_done;
      end else begin
        prev_done = 1'b0;
      end
    end
  end

  task automatic start_load(input logic [10:0] len);
    @(negedge clk);
    load_start = 1'b1;
    load_len   = len;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    host_valid = 1'b0;
    repeat (gap) @(negedge clk);
    host_data  = b;
    host_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (host_ready) begin
        @(negedge clk);
        host_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    host_valid = 1'b0;
    check("host_ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 50 && load_busy; i++) @(negedge clk);
    check(name, 32'(load_busy), 32'd0);
    check({name, "_halt"}, 32'(cpu_halt), 32'd0);
  endtask

  logic [7:0]  b2 [6];
  logic [17:0] w5 [1024];

  initial begin
    logic [7:0] b0, b1, bb2, cs;
    logic       er;

    rst_n = 1'b0; load_start = 1'b0; load_len = '0; host_data = '0;
    host_valid = 1'b0; cpu_addr = '0; cpu_en = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 18'h0;
    #23;
    @(negedge clk);
    check("rst_host_ready", 32'(host_ready), 32'd0);
    check("rst_cpu_halt",   32'(cpu_halt),   32'd0);
    check("rst_load_busy",  32'(load_busy),  32'd0);
    check("rst_load_done",  32'(load_done),  32'd0);
    check("rst_load_err",   32'(load_err),   32'd0);
    check("rst_load_csum",  32'(load_csum),  32'd0);
    rst_n = 1'b1;

    // RUN mux
    @(negedge clk);
    cpu_en = 1'b1; cpu_addr = 10'h155;
    #1;
    check("run_ram_addr", 32'(ram_addr), 32'h155);
    check("run_ram_en",   32'(ram_en),   32'd1);
    check("run_ram_we",   32'(ram_we),   32'd0);
    check("run_ram_din",  32'(ram_data_in), 32'd0);
    check("run_cpu_halt", 32'(cpu_halt), 32'd0);

    // Two-word load
    b2 = '{8'h34, 8'h12, 8'h02, 8'hCD, 8'hAB, 8'h01};
    wq.push_back({10'd0, 18'h21234});
    wq.push_back({10'd1, 18'h1ABCD});
    dq.push_back({1'b0, 8'h43});
    start_load(11'd2);
    check("load_halt",  32'(cpu_halt),  32'd1);
    check("load_busy",  32'(load_busy), 32'd1);
    check("load_ready", 32'(host_ready), 32'd1);
    for (int i = 0; i < 6; i++) send_byte(b2[i], 0);
    wait_idle("load2_idle");
    check("load2_csum_hold", 32'(load_csum), 32'h43);
    check("load2_mem0", 32'(mem[0]), 32'h21234);
    check("load2_mem1", 32'(mem[1]), 32'h1ABCD);
    cpu_addr = 10'h001;
    #1;
    check("load2_run_mux", 32'(ram_addr), 32'h001);

    // Illegal lengths
    start_load(11'd0);
    check("len0_err",   32'(load_err),   32'd1);
    check("len0_busy",  32'(load_busy),  32'd0);
    check("len0_ready", 32'(host_ready), 32'd0);
    start_load(11'd1025);
    @(negedge clk);
    check("len1025_err",   32'(load_err),   32'd1);
    check("len1025_busy",  32'(load_busy),  32'd0);
    check("len1025_ready", 32'(host_ready), 32'd0);

    // Upper bits error, word still written
    wq.push_back({10'd0, 18'h3FFFF});
    dq.push_back({1'b1, 8'hFF ^ 8'hFF ^ 8'h07});
    start_load(11'd1);
    check("start_clears_err", 32'(load_err), 32'd0);
    send_byte(8'hFF, 0); send_byte(8'hFF, 1); send_byte(8'h07, 0);
    wait_idle("upper_idle");
    check("upper_err_sticky", 32'(load_err), 32'd1);
    check("upper_mem0", 32'(mem[0]), 32'h3FFFF);

    // Full-depth load with random bytes and gaps
    cs = '0; er = 1'b0;
    start_load(11'd1024);
    for (int w = 0; w < 1024; w++) begin
      b0 = 8'($urandom); b1 = 8'($urandom); bb2 = 8'($urandom);
      w5[w] = {bb2[1:0], b1, b0};
      cs = cs ^ b0 ^ b1 ^ bb2;
      er = er | (|bb2[7:2]);
      wq.push_back({10'(w), w5[w]});
      if (w == 1023) dq.push_back({er, cs});
      send_byte(b0, $urandom_range(0, 2));
      send_byte(b1, $urandom_range(0, 2));
      send_byte(bb2, $urandom_range(0, 2));
    end
    wait_idle("full_idle");
    check("full_mem0",    32'(mem[0]),    32'(w5[0]));
    check("full_mem511",  32'(mem[511]),  32'(w5[511]));
    check("full_mem1023", 32'(mem[1023]), 32'(w5[1023]));
    check("full_queue",   32'(wq.size() + dq.size()), 32'd0);

    // Reset after four bytes of a two-word load
    wq.push_back({10'd0, 18'h0BEEF & 18'h3FFFF});
    start_load(11'd2);
    send_byte(8'hEF, 0); send_byte(8'hBE, 0); send_byte(8'h00, 0);
    send_byte(8'h55, 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_halt",  32'(cpu_halt),   32'd0);
    check("mid_rst_busy",  32'(load_busy),  32'd0);
    check("mid_rst_ready", 32'(host_ready), 32'd0);
    check("mid_rst_we",    32'(ram_we),     32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_rst_mem0", 32'(mem[0]), 32'h0BEEF);
    check("mid_rst_mem1", 32'(mem[1]), 32'(w5[1]));
    check("final_queues", 32'(wq.size() + dq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
